// File: rtl/xxh32_pkg.sv
// Shared XXH32 constants, controller state encoding and the 32-bit rotate helper.
package xxh32_pkg;

   localparam logic [31:0] P1 = 32'h9E37_79B1;
   localparam logic [31:0] P2 = 32'h85EB_CA77;
   localparam logic [31:0] P3 = 32'hC2B2_AE3D;
   localparam logic [31:0] P4 = 32'h27D4_EB2F;
   localparam logic [31:0] P5 = 32'h1656_67B1;

   typedef enum logic [3:0] {
      StIdle,
      StAbsorb,
      StStripe,
      StMerge,
      StTailW,
      StTailB,
      StAval1,
      StAval2,
      StAval3,
      StDone
   } state_t;

   function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned r);
      return (x << r) | (x >> (32 - r));
   endfunction

endpackage

// File: rtl/xxh32_round.sv
// One XXH32 lane round: rotl(acc + lane*P2, 13) * P1, purely combinational.
module xxh32_round
   import xxh32_pkg::*;
(
   input  logic [31:0] i_acc,
   input  logic [31:0] i_lane,
   output logic [31:0] o_acc
);

   logic [31:0] w_sum;

   assign w_sum = i_acc + i_lane * P2;
   assign o_acc = rotl32(w_sum, 13) * P1;

endmodule

// File: rtl/xxh32_stream_ctrl.sv
// XXH32 sequencer: buffers a word stream into 16-byte stripes, runs the lane rounds, then
// merge, tail and avalanche one step per cycle and offers the digest on a valid/ready port.
module xxh32_stream_ctrl
   import xxh32_pkg::*;
#(
   parameter int unsigned LEN_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] seed,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic [2:0]  in_bytes,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_hash,
   output logic        busy
);

   state_t           r_state, w_state_nxt;
   logic [31:0]      r_buf [4];
   logic [31:0]      r_v [4];
   logic [31:0]      w_round [4];
   logic [2:0]       r_cnt;
   logic [1:0]       r_nb, r_ti, r_bi;
   logic [31:0]      r_seed, r_acc;
   logic             r_stripe_seen, r_last;
   logic [LEN_W-1:0] r_len;

   logic             w_accept;
   logic [2:0]       w_bytes, w_cnt_inc;
   logic [31:0]      w_merge, w_word_step, w_byte_step, w_av1, w_av2;
   logic [7:0]       w_byte;

   assign in_ready  = (r_state == StIdle) || (r_state == StAbsorb && r_cnt < 3'd4);
   assign out_valid = (r_state == StDone);
   assign out_hash  = r_acc;
   assign busy      = (r_state != StIdle);

   assign w_accept  = in_valid && in_ready;
   assign w_bytes   = !in_last ? 3'd4 : (in_bytes > 3'd4) ? 3'd4 : in_bytes;
   assign w_cnt_inc = r_cnt + ((w_bytes == 3'd4) ? 3'd1 : 3'd0);

   for (genvar g = 0; g < 4; g++) begin : g_lane
      xxh32_round u_round (
         .i_acc  (r_v[g]),
         .i_lane (r_buf[g]),
         .o_acc  (w_round[g])
      );
   end

   assign w_merge = (r_stripe_seen ? (rotl32(r_v[0], 1) + rotl32(r_v[1], 7) +
                                      rotl32(r_v[2], 12) + rotl32(r_v[3], 18))
                                   : (r_seed + P5)) + r_len[31:0];
   assign w_word_step = rotl32(r_acc + r_buf[r_ti] * P3, 17) * P4;
   // The partial word always sits in the slot just after the last full word.
   assign w_byte      = r_buf[r_cnt[1:0]][{r_bi, 3'b000} +: 8];
   assign w_byte_step = rotl32(r_acc + {24'd0, w_byte} * P5, 11) * P1;
   assign w_av1       = (r_acc ^ (r_acc >> 15)) * P2;
   assign w_av2       = (r_acc ^ (r_acc >> 13)) * P3;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle, StAbsorb: begin
            if (w_accept) begin
               if (w_cnt_inc == 3'd4) w_state_nxt = StStripe;
               else if (in_last)      w_state_nxt = StMerge;
               else                   w_state_nxt = StAbsorb;
            end
         end
         StStripe: w_state_nxt = r_last ? StMerge : StAbsorb;
         StMerge: begin
            if (r_cnt != 3'd0)     w_state_nxt = StTailW;
            else if (r_nb != 2'd0) w_state_nxt = StTailB;
            else                   w_state_nxt = StAval1;
         end
         StTailW: begin
            if ({1'b0, r_ti} + 3'd1 == r_cnt) w_state_nxt = (r_nb != 2'd0) ? StTailB : StAval1;
         end
         StTailB: begin
            if ({1'b0, r_bi} + 3'd1 == {1'b0, r_nb}) w_state_nxt = StAval1;
         end
         StAval1: w_state_nxt = StAval2;
         StAval2: w_state_nxt = StAval3;
         StAval3: w_state_nxt = StDone;
         StDone:  if (out_ready) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_cnt         <= '0;
         r_nb          <= '0;
         r_ti          <= '0;
         r_bi          <= '0;
         r_seed        <= '0;
         r_acc         <= '0;
         r_stripe_seen <= 1'b0;
         r_last        <= 1'b0;
         r_len         <= '0;
         for (int i = 0; i < 4; i++) begin
            r_buf[i] <= '0;
            r_v[i]   <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            if (w_bytes == 3'd4) begin
               r_buf[r_cnt[1:0]] <= in_data;
               r_cnt             <= w_cnt_inc;
            end else if (w_bytes != 3'd0) begin
               r_buf[r_cnt[1:0]] <= in_data;
               r_nb              <= w_bytes[1:0];
            end
            r_last <= in_last;
            if (r_state == StIdle) begin
               r_seed        <= seed;
               r_v[0]        <= seed + P1 + P2;
               r_v[1]        <= seed + P2;
               r_v[2]        <= seed;
               r_v[3]        <= seed - P1;
               r_stripe_seen <= 1'b0;
               r_len         <= LEN_W'(w_bytes);
            end else begin
               r_len <= r_len + LEN_W'(w_bytes);
            end
         end
         case (r_state)
            StStripe: begin
               for (int i = 0; i < 4; i++) begin
                  r_v[i]   <= w_round[i];
                  r_buf[i] <= '0;
               end
               r_stripe_seen <= 1'b1;
               r_cnt         <= '0;
            end
            StMerge: begin
               r_acc <= w_merge;
               r_ti  <= '0;
               r_bi  <= '0;
            end
            StTailW: begin
               r_acc <= w_word_step;
               r_ti  <= r_ti + 2'd1;
            end
            StTailB: begin
               r_acc <= w_byte_step;
               r_bi  <= r_bi + 2'd1;
            end
            StAval1: r_acc <= w_av1;
            StAval2: r_acc <= w_av2;
            StAval3: r_acc <= r_acc ^ (r_acc >> 16);
            StDone: begin
               if (out_ready) begin
                  r_cnt <= '0;
                  r_nb  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xxh32_stream_ctrl.sv
// Directed vector table plus hand sequences and random messages, checked against a byte-level
// XXH32 reference model.
module tb_xxh32_stream_ctrl;

   localparam logic [31:0] K1 = 32'h9E37_79B1;
   localparam logic [31:0] K2 = 32'h85EB_CA77;
   localparam logic [31:0] K3 = 32'hC2B2_AE3D;
   localparam logic [31:0] K4 = 32'h27D4_EB2F;
   localparam logic [31:0] K5 = 32'h1656_67B1;

   typedef struct {
      string       name;
      logic [31:0] seed;
      int          len;
      logic [7:0]  base;
      int          style;
      int          lat;
      logic [31:0] hash;
      logic        use_model;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] seed;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [2:0]  in_bytes;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_hash;
   logic        busy;

   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          acc_edge = 0;
   int          beat_idx = 0;
   int          waits [32];
   logic [7:0]  msg [128];
   vec_t        tv [9];

   xxh32_stream_ctrl #(.LEN_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .seed      (seed),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_hash  (out_hash),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] rol(input logic [31:0] x, input int r);
      return (x << r) | (x >> (32 - r));
   endfunction

   function automatic logic [31:0] wd(input int p);
      return {msg[p+3], msg[p+2], msg[p+1], msg[p]};
   endfunction

   function automatic logic [31:0] lane(input logic [31:0] v, input logic [31:0] w);
      return rol(v + w * K2, 13) * K1;
   endfunction

   function automatic logic [31:0] ref_hash(input logic [31:0] s, input int n);
      logic [31:0] h, a, b, c, d;
      int p;
      p = 0;
      if (n >= 16) begin
         a = s + K1 + K2;
         b = s + K2;
         c = s;
         d = s - K1;
         while (p + 16 <= n) begin
            a = lane(a, wd(p));
            b = lane(b, wd(p + 4));
            c = lane(c, wd(p + 8));
            d = lane(d, wd(p + 12));
            p += 16;
         end
         h = rol(a, 1) + rol(b, 7) + rol(c, 12) + rol(d, 18);
      end else begin
         h = s + K5;
      end
      h = h + 32'(n);
      while (p + 4 <= n) begin
         h = rol(h + wd(p) * K3, 17) * K4;
         p += 4;
      end
      while (p < n) begin
         h = rol(h + {24'd0, msg[p]} * K5, 11) * K1;
         p++;
      end
      h = (h ^ (h >> 15)) * K2;
      h = (h ^ (h >> 13)) * K3;
      h = h ^ (h >> 16);
      return h;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Called and returns at a falling edge; acc_edge records the accepting rising edge.
   task automatic beat(input logic [31:0] d, input logic last, input logic [2:0] nb,
                       input logic [31:0] s, input int gapmax);
      int t;
      int g;
      g = int'($urandom_range(0, gapmax));
      repeat (g) begin
         in_valid = 1'b0;
         seed     = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      in_bytes = nb;
      seed     = (beat_idx == 0) ? s : $urandom;
      t = 0;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL beat_accept: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      end else begin
         @(negedge clk);
      end
      if (beat_idx < 32) waits[beat_idx] = t;
      beat_idx++;
      acc_edge = cyc;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_bytes = 3'($urandom);
      in_data  = $urandom;
      seed     = $urandom;
   endtask

   // style 1: trailing empty last beat; style 2: full last word flagged with in_bytes=7.
   task automatic send_msg(input logic [31:0] s, input int n, input int style, input int gapmax);
      int nf;
      int rem;
      int nfull;
      logic [31:0] w;
      nf = n / 4;
      rem = n % 4;
      beat_idx = 0;
      if (n == 0) begin
         beat($urandom, 1'b1, 3'd0, s, gapmax);
         return;
      end
      nfull = (rem != 0 || style == 1) ? nf : nf - 1;
      for (int i = 0; i < nfull; i++) beat(wd(4 * i), 1'b0, 3'($urandom), s, gapmax);
      if (rem != 0) begin
         w = $urandom;
         for (int b = 0; b < rem; b++) w[8*b +: 8] = msg[4 * nf + b];
         beat(w, 1'b1, 3'(rem), s, gapmax);
      end else if (style == 1) begin
         beat($urandom, 1'b1, 3'd0, s, gapmax);
      end else begin
         beat(wd(4 * (nf - 1)), 1'b1, (style == 2) ? 3'd7 : 3'd4, s, gapmax);
      end
   endtask

   task automatic get_digest(input logic [31:0] exp, input int lat, input int stall,
                             input string name);
      int t;
      t = 0;
      while (!out_valid && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         total++;
         bad++;
         $display("FAIL %s/timeout: out_valid=0 after %0d cycles, required 1", name, t);
         return;
      end
      if (lat >= 0) chk({name, "/latency"}, 64'(cyc - acc_edge), 64'(lat));
      chk({name, "/hash"}, {32'd0, out_hash}, {32'd0, exp});
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({name, "/hold"}, {30'd0, out_valid, in_ready, out_hash}, {30'd0, 1'b1, 1'b0, exp});
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, "/release_valid"}, {63'd0, out_valid}, 64'd0);
      chk({name, "/release_ready"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      logic [31:0] exp;
      logic [31:0] exp2;
      int n;
      int st;
      logic [31:0] s;

      tv[0] = '{"empty",   32'h0000_0000,  0, 8'h00, 0, 4, 32'h02CC_5D05, 1'b0};
      tv[1] = '{"a",       32'h0000_0000,  1, 8'h61, 0, 5, 32'h550D_7456, 1'b0};
      tv[2] = '{"abc",     32'h0000_0000,  3, 8'h61, 0, 7, 32'h32D1_53FF, 1'b0};
      tv[3] = '{"stripe16", 32'h0000_0000, 16, 8'h00, 0, 5, 32'h0, 1'b1};
      tv[4] = '{"word4",   32'h9E37_79B1,  4, 8'h10, 0, 5, 32'h0, 1'b1};
      tv[5] = '{"empty_last", 32'h0000_0007, 8, 8'h20, 1, 6, 32'h0, 1'b1};
      tv[6] = '{"bytes7",  32'hDEAD_BEEF,  4, 8'h30, 2, 5, 32'h0, 1'b1};
      tv[7] = '{"stripe32", 32'h0000_0001, 32, 8'h40, 0, 5, 32'h0, 1'b1};
      tv[8] = '{"len21",   32'hFFFF_FFFF, 21, 8'h80, 0, 6, 32'h0, 1'b1};

      rst = 1'b1;
      seed = '0;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      in_bytes = '0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset/in_ready", {63'd0, in_ready}, 64'd1);
      chk("reset/out_valid", {63'd0, out_valid}, 64'd0);
      chk("reset/out_hash", {32'd0, out_hash}, 64'd0);
      chk("reset/busy", {63'd0, busy}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 9; k++) begin
         for (int i = 0; i < 128; i++) msg[i] = 8'(int'(tv[k].base) + i);
         exp = tv[k].use_model ? ref_hash(tv[k].seed, tv[k].len) : tv[k].hash;
         send_msg(tv[k].seed, tv[k].len, tv[k].style, 0);
         chk({tv[k].name, "/busy"}, {63'd0, busy}, 64'd1);
         get_digest(exp, tv[k].lat, 1, tv[k].name);
      end

      // Backpressure, then a new message must be taken on the very next cycle.
      for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
      exp = ref_hash(32'h0000_0055, 5);
      send_msg(32'h0000_0055, 5, 0, 0);
      get_digest(exp, 6, 10, "bp");
      for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
      exp2 = ref_hash(32'h0000_00A5, 9);
      send_msg(32'h0000_00A5, 9, 0, 0);
      chk("bp/next_first_wait", 64'(waits[0]), 64'd0);
      get_digest(exp2, 7, 0, "bp2");

      // Reset while in the word-tail phase of a 23-byte message, then hash it again.
      for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
      exp = ref_hash(32'h0000_1234, 23);
      send_msg(32'h0000_1234, 23, 0, 0);
      chk("rst/stripe_wait", 64'(waits[4]), 64'd1);
      chk("rst/post_stripe_wait", 64'(waits[5]), 64'd0);
      @(negedge clk);
      chk("rst/busy_before", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      #1;
      chk("rst/in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst/out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst/out_hash", {32'd0, out_hash}, 64'd0);
      chk("rst/busy", {63'd0, busy}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_msg(32'h0000_1234, 23, 0, 0);
      get_digest(exp, 8, 2, "rst/rehash");

      for (int r = 0; r < 500; r++) begin
         n = int'($urandom_range(0, 100));
         s = $urandom;
         for (int i = 0; i < 128; i++) msg[i] = 8'($urandom);
         st = (n % 4 == 0 && n > 0) ? int'($urandom_range(0, 2)) : 0;
         exp = ref_hash(s, n);
         send_msg(s, n, st, 2);
         get_digest(exp, -1, int'($urandom_range(0, 3)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/xxh32_stream_ctrl.md
Name: xxh32_stream_ctrl

Overview:
- Sequencing controller for the XXH32 hash datapath.
- Accepts a message as a stream of little-endian 32-bit words over a valid/ready handshake and buffers them into 16-byte stripes.
- Drives four parallel lane-round instances per stripe, then runs merge, tail and avalanche steps one per cycle.
- Presents the 32-bit digest on a valid/ready output; sits between the word-stream source and the digest consumer.

Parameters:
- LEN_W, 32: message byte-length counter width (>=32); the low 32 bits feed the merge step.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- seed  in  32  hash seed; sampled on the first accepted beat of each message
- in_valid  in  1  input word valid
- in_ready  out  1  controller can accept a word
- in_data  in  32  message word; [7:0] is the earliest byte
- in_last  in  1  final word of the message
- in_bytes  in  3  valid bytes in the final word, 0..4, packed in the low lanes; ignored unless in_last
- out_valid  out  1  digest valid
- out_ready  in  1  consumer accepts the digest
- out_hash  out  32  XXH32 digest
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, immediate): state IDLE, buffer empty, length 0, in_ready=1, out_valid=0, out_hash=0, busy=0. Reset mid-message discards all progress; there is no other abort.
- Constants: P1=0x9E3779B1, P2=0x85EBCA77, P3=0xC2B2AE3D, P4=0x27D4EB2F, P5=0x165667B1. All arithmetic is mod 2^32.
- Beat acceptance:
  - A beat is accepted on the edge where in_valid && in_ready.
  - Non-last beats count as 4 bytes. A last beat counts min(in_bytes,4) bytes.
  - in_bytes=0 on a last beat adds nothing, which supports empty messages.
- First beat (IDLE -> ABSORB): latch seed; set v1=seed+P1+P2, v2=seed+P2, v3=seed, v4=seed-P1; clear stripe_seen.
- ABSORB:
  - Each beat writes to buffer slot cnt (0..3). A full word is 4 bytes.
  - When cnt reaches 4 full words, go to STRIPE; this applies even when that beat is last.
  - On a last beat that does not complete a stripe, go to MERGE.
- STRIPE (1 cycle, in_ready=0):
  - vi = rotl(vi + lane_i*P2, 13)*P1 for all four lanes in parallel; set stripe_seen; clear the buffer.
  - Next state is ABSORB, or MERGE if the stripe's 4th word was the last beat.
- MERGE (1 cycle):
  - acc = stripe_seen ? rotl(v1,1)+rotl(v2,7)+rotl(v3,12)+rotl(v4,18) : seed+P5.
  - Then acc += len[31:0].
- TAIL_W: one cycle per remaining full buffered word, in order: acc = rotl(acc + w*P3, 17)*P4.
- TAIL_B: one cycle per byte of a partial last word, low byte first: acc = rotl(acc + b*P5, 11)*P1.
- Avalanche, one cycle each:
  - AVAL1: acc ^= acc>>15; acc *= P2
  - AVAL2: acc ^= acc>>13; acc *= P3
  - AVAL3: acc ^= acc>>16
  - Then go to DONE.
- DONE: out_valid=1; out_hash is stable while out_valid && !out_ready. On the handshake edge go to IDLE with out_valid=0; in_ready=1 from the next cycle.
- in_ready is high only in IDLE, and in ABSORB while cnt<4; it is low in all other states. The block never accepts a beat in the same cycle it issues a digest.
- Latency: the last beat is accepted at edge E0. out_valid rises at edge E(S+1+nw+nb+3), where:
  - S=1 if the last beat completed a stripe, else 0
  - nw = remaining full words
  - nb = partial bytes
- Length counter: LEN_W-bit and wrapping; only bits [31:0] are used.
- Illegal inputs: in_bytes>4 is treated as 4. Non-last beats always count as 4 bytes.

Decomposition:
- xxh32_pkg holds:
  - P1..P5 as localparams
  - state enum typedef (IDLE, ABSORB, STRIPE, MERGE, TAIL_W, TAIL_B, AVAL1, AVAL2, AVAL3, DONE)
  - rotl32 function
- Sub-module xxh32_round (combinational: input acc and lane, output rotl(acc+lane*P2,13)*P1), instantiated 4x for the STRIPE step.
- Golden-vector CSVs for the bench are parsed with the existing helper package.

Test Plan:
- Empty message: seed=0, one beat with in_last=1, in_bytes=0 -> out_hash=0x02CC5D05; out_valid rises at E4.
- "abc": seed=0, in_data=0x00636261, in_last=1, in_bytes=3 -> out_hash=0x32D153FF; out_valid rises at E7; exactly 3 TAIL_B cycles.
- Exact 16-byte message, bytes 0x00..0x0F, seed 0 -> digest matches the CSV golden value; in_ready low exactly one cycle after the 4th beat; out_valid rises at E5.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_hash stable and in_ready=0 throughout; release -> out_valid falls and the next message's first beat is accepted the following cycle.
- Assert rst during TAIL_W of a 23-byte message -> all outputs take reset values immediately; after release, the same message hashed again matches the golden value.
- 500 random messages, lengths 0..100, random seeds, random in_valid gaps and out_ready stalls -> every digest matches the CSV golden vectors.
